// File: rtl/dsp_mac_sequencer.sv
`default_nettype none
// ============================================================================
// dsp_mac_sequencer : feeds (a,b) beats to an 18x18 DSP slice, accumulates each
// vector in P and holds the final sum. Optional macro: DSP_SEQ_OVF_EN. Rev 1.0
// ============================================================================

module dsp_mac_sequencer #(
   parameter int DSP_LAT = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        IN_VALID,
   output logic        IN_READY,
   input  logic [17:0] IN_A,
   input  logic [17:0] IN_B,
   input  logic        IN_LAST,
   output logic [17:0] DSP_A,
   output logic [17:0] DSP_B,
   output logic [7:0]  DSP_OPMODE,
   output logic        DSP_CE,
   output logic        DSP_CEP,
   output logic        DSP_RSTP,
   input  logic [47:0] DSP_P,
   output logic        RES_VALID,
   input  logic        RES_READY,
   output logic [47:0] RES,
   output logic        RES_OVF
);

   localparam logic [7:0] c_OPMODE_LOAD = 8'h01;
   localparam logic [7:0] c_OPMODE_ACC  = 8'h09;

   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } tag_t;

   tag_t        r_tag [0:DSP_LAT];
   logic        r_first;
   logic [17:0] r_dsp_a;
   logic [17:0] r_dsp_b;
   logic [7:0]  r_opmode;
   logic [47:0] r_res;
   logic        r_res_valid;
   logic        w_accept;
   logic        w_capture;
   logic        w_last_in_flight;

   // Stage DSP_LAT is included so a new vector end is only admitted once the
   // previous result slot is known to be free when the new sum arrives.
   always_comb begin
      w_last_in_flight = 1'b0;
      for (int k = 0; k <= DSP_LAT; k++) begin
         if (r_tag[k].valid && r_tag[k].last) begin
            w_last_in_flight = 1'b1;
         end
      end
   end

   assign IN_READY  = !RST && !(IN_LAST && (w_last_in_flight || (r_res_valid && !RES_READY)));
   assign w_accept  = IN_VALID && IN_READY;
   assign w_capture = r_tag[DSP_LAT].valid && r_tag[DSP_LAT].last;

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int k = 0; k <= DSP_LAT; k++) begin
            r_tag[k] <= '0;
         end
         r_first     <= 1'b1;
         r_dsp_a     <= '0;
         r_dsp_b     <= '0;
         r_opmode    <= '0;
         r_res       <= '0;
         r_res_valid <= 1'b0;
      end else begin
         r_tag[0] <= {w_accept, w_accept & r_first, w_accept & IN_LAST};
         for (int k = 1; k <= DSP_LAT; k++) begin
            r_tag[k] <= r_tag[k-1];
         end
         if (w_accept) begin
            r_dsp_a <= IN_A;
            r_dsp_b <= IN_B;
            r_first <= IN_LAST;
         end
         // Loaded one stage early so it lines up with CEP for the P edge.
         if (r_tag[DSP_LAT-2].valid) begin
            r_opmode <= r_tag[DSP_LAT-2].first ? c_OPMODE_LOAD : c_OPMODE_ACC;
         end
         if (w_capture) begin
            r_res       <= DSP_P;
            r_res_valid <= 1'b1;
         end else if (RES_READY) begin
            r_res       <= '0;
            r_res_valid <= 1'b0;
         end
      end
   end

   assign DSP_A      = r_dsp_a;
   assign DSP_B      = r_dsp_b;
   assign DSP_OPMODE = r_opmode;
   assign DSP_CEP    = r_tag[DSP_LAT-1].valid;
   assign DSP_CE     = !RST;
   assign DSP_RSTP   = RST;
   assign RES        = r_res;
   assign RES_VALID  = r_res_valid;

`ifdef DSP_SEQ_OVF_EN
   localparam logic [12:0] c_CNT_SAT  = 13'd4097;
   localparam logic [12:0] c_SAFE_LEN = 13'd4096;

   logic [12:0] r_beat_cnt;
   logic        r_ovf_pend;
   logic        r_res_ovf;

   // r_beat_cnt counts the beats preceding the current one in this vector.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_beat_cnt <= '0;
         r_ovf_pend <= 1'b0;
         r_res_ovf  <= 1'b0;
      end else begin
         if (w_accept) begin
            if (IN_LAST) begin
               r_beat_cnt <= '0;
               r_ovf_pend <= (r_beat_cnt >= c_SAFE_LEN);
            end else if (r_beat_cnt != c_CNT_SAT) begin
               r_beat_cnt <= r_beat_cnt + 13'd1;
            end
         end
         if (w_capture) begin
            r_res_ovf <= r_ovf_pend;
         end else if (RES_READY) begin
            r_res_ovf <= 1'b0;
         end
      end
   end

   assign RES_OVF = r_res_ovf;
`else
   assign RES_OVF = 1'b0;
`endif

endmodule

`default_nettype wire
